// File: rtl/addr_decode_cfg_pkg.sv
// Shared types for the configurable address decoder: one rule slot and its hit test.
// Fields are sized for the widest supported configuration; narrower users zero-extend.
package addr_decode_cfg_pkg;

    localparam int unsigned MaxAddrWidth = 32'd64;
    localparam int unsigned MaxIdxWidth  = 32'd8;

    typedef logic [MaxAddrWidth-1:0] addr_t;

    typedef struct packed {
        logic                   en;
        logic [MaxIdxWidth-1:0] idx;
        addr_t                  start_addr;
        addr_t                  end_addr;
    } rule_t;

    // Half-open interval test [start, end); an empty interval never hits
    function automatic logic rule_match(input rule_t rule, input addr_t addr);
        return rule.en && (rule.start_addr <= addr) && (addr < rule.end_addr);
    endfunction

endpackage

// File: rtl/addr_decode_cfg_match.sv
// Combinational matcher over the active rule table; the highest matching slot wins.
module addr_decode_cfg_match
    import addr_decode_cfg_pkg::*;
#(
    parameter int unsigned NoRules   = 32'd8,
    parameter int unsigned IdxWidth  = 32'd2,
    parameter int unsigned RuleWidth = 32'd3
) (
    input  rule_t [NoRules-1:0] rules_i,
    input  addr_t               addr_i,
    output logic [IdxWidth-1:0]  idx_o,
    output logic [RuleWidth-1:0] rule_o,
    output logic                 match_o
);

    rule_t [NoRules-1:0] gated_s;

    // Disabled slots collapse to an empty [0,0) range so they can never hit
    always_comb begin
        gated_s = rules_i;
        for (int unsigned r = 0; r < NoRules; r++) begin
            if (!rules_i[r].en) begin
                gated_s[r].start_addr = '0;
                gated_s[r].end_addr   = '0;
            end else begin
                gated_s[r] = rules_i[r];
            end
        end
    end

    // Ascending scan: the last hit, i.e. the highest slot, is what remains
    always_comb begin
        idx_o   = '0;
        rule_o  = '0;
        match_o = 1'b0;
        for (int unsigned r = 0; r < NoRules; r++) begin
            if (rule_match(gated_s[r], addr_i)) begin
                idx_o   = gated_s[r].idx[IdxWidth-1:0];
                rule_o  = RuleWidth'(r);
                match_o = 1'b1;
            end else begin
            end
        end
    end

endmodule

// File: rtl/addr_decode_cfg.sv
// Registered address decoder with a shadow/active rule table, valid/ready on both sides
// and a saturating decode-error counter.
module addr_decode_cfg
    import addr_decode_cfg_pkg::*;
#(
    parameter int unsigned NoIndices = 32'd4,
    parameter int unsigned NoRules   = 32'd8,
    parameter int unsigned AddrWidth = 32'd32,
    parameter int unsigned CntWidth  = 32'd16,
    localparam int unsigned IdxWidth  = (NoIndices > 32'd1) ? $clog2(NoIndices) : 32'd1,
    localparam int unsigned RuleWidth = (NoRules > 32'd1) ? $clog2(NoRules) : 32'd1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [AddrWidth-1:0] in_addr_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [AddrWidth-1:0] out_addr_o,
    output logic [IdxWidth-1:0]  out_idx_o,
    output logic [RuleWidth-1:0] out_rule_o,
    output logic                 out_dec_valid_o,
    output logic                 out_dec_error_o,
    input  logic                 en_default_idx_i,
    input  logic [IdxWidth-1:0]  default_idx_i,
    input  logic                 cfg_we_i,
    input  logic [RuleWidth-1:0] cfg_rule_i,
    input  logic                 cfg_en_i,
    input  logic [IdxWidth-1:0]  cfg_idx_i,
    input  logic [AddrWidth-1:0] cfg_start_i,
    input  logic [AddrWidth-1:0] cfg_end_i,
    input  logic                 cfg_commit_i,
    output logic                 cfg_err_o,
    output logic [CntWidth-1:0]  err_cnt_o
);

    rule_t [NoRules-1:0] shadow_q, shadow_d, active_q, active_d;
    logic                 out_valid_q, out_valid_d;
    logic [AddrWidth-1:0] out_addr_q, out_addr_d;
    logic [IdxWidth-1:0]  out_idx_q, out_idx_d;
    logic [RuleWidth-1:0] out_rule_q, out_rule_d;
    logic                 out_dec_valid_q, out_dec_valid_d;
    logic                 out_dec_error_q, out_dec_error_d;
    logic                 cfg_err_q, cfg_err_d;
    logic [CntWidth-1:0]  err_cnt_q, err_cnt_d;

    logic [IdxWidth-1:0]  match_idx_s;
    logic [RuleWidth-1:0] match_rule_s;
    logic                 match_s;
    logic                 in_ready_s, accept_s, dec_error_s, cfg_ok_s;
    rule_t                cfg_rule_s;

    addr_decode_cfg_match #(
        .NoRules   (NoRules),
        .IdxWidth  (IdxWidth),
        .RuleWidth (RuleWidth)
    ) u_match (
        .rules_i (active_q),
        .addr_i  (addr_t'(in_addr_i)),
        .idx_o   (match_idx_s),
        .rule_o  (match_rule_s),
        .match_o (match_s)
    );

    assign in_ready_s  = !out_valid_q || out_ready_i;
    assign accept_s    = in_valid_i && in_ready_s;
    assign dec_error_s = !match_s && !en_default_idx_i;

    // Screen an incoming rule write; disabled rules are only checked for a legal slot
    always_comb begin
        cfg_rule_s            = '0;
        cfg_rule_s.en         = cfg_en_i;
        cfg_rule_s.idx        = MaxIdxWidth'(cfg_idx_i);
        cfg_rule_s.start_addr = addr_t'(cfg_start_i);
        cfg_rule_s.end_addr   = addr_t'(cfg_end_i);
        if (32'(cfg_rule_i) >= NoRules) begin
            cfg_ok_s = 1'b0;
        end else if (cfg_en_i && ((32'(cfg_idx_i) >= NoIndices) || (cfg_start_i > cfg_end_i))) begin
            cfg_ok_s = 1'b0;
        end else begin
            cfg_ok_s = 1'b1;
        end
    end

    // Shadow write, then commit copies the post-write shadow so a same-cycle write is included
    always_comb begin
        shadow_d = shadow_q;
        for (int unsigned r = 0; r < NoRules; r++) begin
            if (cfg_we_i && cfg_ok_s && (32'(cfg_rule_i) == r)) begin
                shadow_d[r] = cfg_rule_s;
            end else begin
                shadow_d[r] = shadow_q[r];
            end
        end
        if (cfg_commit_i) begin
            active_d = shadow_d;
        end else begin
            active_d = active_q;
        end
        cfg_err_d = cfg_we_i && !cfg_ok_s;
    end

    // Output register: load on accept, drain on ready, otherwise hold
    always_comb begin
        out_valid_d     = out_valid_q;
        out_addr_d      = out_addr_q;
        out_idx_d       = out_idx_q;
        out_rule_d      = out_rule_q;
        out_dec_valid_d = out_dec_valid_q;
        out_dec_error_d = out_dec_error_q;
        if (accept_s) begin
            out_valid_d     = 1'b1;
            out_addr_d      = in_addr_i;
            out_rule_d      = match_rule_s;
            out_dec_valid_d = match_s;
            out_dec_error_d = dec_error_s;
            if (match_s) begin
                out_idx_d = match_idx_s;
            end else if (en_default_idx_i) begin
                out_idx_d = default_idx_i;
            end else begin
                out_idx_d = '0;
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (accept_s && dec_error_s && (err_cnt_q != {CntWidth{1'b1}})) begin
            err_cnt_d = err_cnt_q + CntWidth'(1);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_q        <= '0;
            active_q        <= '0;
            out_valid_q     <= 1'b0;
            out_addr_q      <= '0;
            out_idx_q       <= '0;
            out_rule_q      <= '0;
            out_dec_valid_q <= 1'b0;
            out_dec_error_q <= 1'b0;
            cfg_err_q       <= 1'b0;
            err_cnt_q       <= '0;
        end else begin
            shadow_q        <= shadow_d;
            active_q        <= active_d;
            out_valid_q     <= out_valid_d;
            out_addr_q      <= out_addr_d;
            out_idx_q       <= out_idx_d;
            out_rule_q      <= out_rule_d;
            out_dec_valid_q <= out_dec_valid_d;
            out_dec_error_q <= out_dec_error_d;
            cfg_err_q       <= cfg_err_d;
            err_cnt_q       <= err_cnt_d;
        end
    end

    assign in_ready_o      = in_ready_s;
    assign out_valid_o     = out_valid_q;
    assign out_addr_o      = out_addr_q;
    assign out_idx_o       = out_idx_q;
    assign out_rule_o      = out_rule_q;
    assign out_dec_valid_o = out_dec_valid_q;
    assign out_dec_error_o = out_dec_error_q;
    assign cfg_err_o       = cfg_err_q;
    assign err_cnt_o       = err_cnt_q;

endmodule

// File: tb/tb_addr_decode_cfg.sv
// Directed bench for addr_decode_cfg: a transaction-level model checked every cycle,
// plus a narrow-counter / fewer-rules instance for saturation and slot-range rejection.
module tb_addr_decode_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i, in_valid_i, out_ready_i, en_default_idx_i;
    logic        cfg_we_i, cfg_en_i, cfg_commit_i;
    logic [31:0] in_addr_i, cfg_start_i, cfg_end_i;
    logic [1:0]  default_idx_i, cfg_idx_i;
    logic [2:0]  cfg_rule_i;

    logic        in_ready_o, out_valid_o, out_dec_valid_o, out_dec_error_o, cfg_err_o;
    logic [31:0] out_addr_o;
    logic [1:0]  out_idx_o;
    logic [2:0]  out_rule_o;
    logic [15:0] err_cnt_o;

    logic        s_in_ready, s_out_valid, s_dec_valid, s_dec_error, s_cfg_err;
    logic [31:0] s_out_addr;
    logic [1:0]  s_out_idx;
    logic [2:0]  s_out_rule;
    logic [2:0]  s_err_cnt;

    addr_decode_cfg dut (
        .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_addr_i(in_addr_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_addr_o(out_addr_o), .out_idx_o(out_idx_o), .out_rule_o(out_rule_o),
        .out_dec_valid_o(out_dec_valid_o), .out_dec_error_o(out_dec_error_o),
        .en_default_idx_i(en_default_idx_i), .default_idx_i(default_idx_i),
        .cfg_we_i(cfg_we_i), .cfg_rule_i(cfg_rule_i), .cfg_en_i(cfg_en_i), .cfg_idx_i(cfg_idx_i),
        .cfg_start_i(cfg_start_i), .cfg_end_i(cfg_end_i), .cfg_commit_i(cfg_commit_i),
        .cfg_err_o(cfg_err_o), .err_cnt_o(err_cnt_o)
    );

    addr_decode_cfg #(.NoIndices(3), .NoRules(6), .CntWidth(3)) dut_small (
        .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(s_in_ready),
        .in_addr_i(in_addr_i), .out_valid_o(s_out_valid), .out_ready_i(out_ready_i),
        .out_addr_o(s_out_addr), .out_idx_o(s_out_idx), .out_rule_o(s_out_rule),
        .out_dec_valid_o(s_dec_valid), .out_dec_error_o(s_dec_error),
        .en_default_idx_i(en_default_idx_i), .default_idx_i(default_idx_i),
        .cfg_we_i(cfg_we_i), .cfg_rule_i(cfg_rule_i), .cfg_en_i(cfg_en_i), .cfg_idx_i(cfg_idx_i),
        .cfg_start_i(cfg_start_i), .cfg_end_i(cfg_end_i), .cfg_commit_i(cfg_commit_i),
        .cfg_err_o(s_cfg_err), .err_cnt_o(s_err_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { logic [31:0] addr; int idx; int rule; bit dv; bit de; } exp_t;
    typedef struct { bit en; int idx; longint st; longint en_addr; } mrule_t;

    exp_t   exp_q[$];
    mrule_t sh[8];
    mrule_t act[8];
    int     m_cnt, m_cnt_s;
    bit     m_cfg_err, m_cfg_err_s;
    bit     started = 1'b0;
    int     hs_cnt = 0;

    function automatic exp_t model_decode(input logic [31:0] a);
        exp_t e;
        bit hit = 1'b0;
        e.addr = a; e.idx = 0; e.rule = 0; e.dv = 1'b0; e.de = 1'b0;
        for (int r = 7; r >= 0; r--) begin
            if (!hit && act[r].en && (longint'(a) >= act[r].st) && (longint'(a) < act[r].en_addr)) begin
                hit = 1'b1; e.idx = act[r].idx; e.rule = r; e.dv = 1'b1;
            end
        end
        if (!hit) begin
            if (en_default_idx_i) e.idx = int'(default_idx_i);
            else e.de = 1'b1;
        end
        return e;
    endfunction

    function automatic bit rejects(input int nrules, input int nidx);
        return (int'(cfg_rule_i) >= nrules) ||
               (cfg_en_i && ((int'(cfg_idx_i) >= nidx) || (cfg_start_i > cfg_end_i)));
    endfunction

    always @(posedge clk) begin
        exp_t e;
        bit   rdy;
        started = 1'b1;
        if (rst_i) begin
            exp_q.delete();
            for (int i = 0; i < 8; i++) begin
                sh[i] = '{1'b0, 0, 0, 0};
                act[i] = '{1'b0, 0, 0, 0};
            end
            m_cnt = 0; m_cnt_s = 0; m_cfg_err = 1'b0; m_cfg_err_s = 1'b0;
        end else begin
            rdy = (exp_q.size() == 0) || out_ready_i;
            if ((exp_q.size() != 0) && out_ready_i) void'(exp_q.pop_front());
            if (in_valid_i && rdy) begin
                e = model_decode(in_addr_i);
                exp_q.push_back(e);
                if (e.de) begin
                    if (m_cnt < 65535) m_cnt++;
                    if (m_cnt_s < 7) m_cnt_s++;
                end
            end
            m_cfg_err   = cfg_we_i && rejects(8, 4);
            m_cfg_err_s = cfg_we_i && rejects(6, 3);
            if (cfg_we_i && !rejects(8, 4))
                sh[cfg_rule_i] = '{cfg_en_i, int'(cfg_idx_i), longint'(cfg_start_i), longint'(cfg_end_i)};
            if (cfg_commit_i) act = sh;
        end
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", in_ready_o, (exp_q.size() == 0) || out_ready_i);
            chk("out_valid", out_valid_o, exp_q.size() != 0);
            chk("s_out_valid", s_out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                chk("out_addr", out_addr_o, exp_q[0].addr);
                chk("out_idx", out_idx_o, exp_q[0].idx);
                chk("out_rule", out_rule_o, exp_q[0].rule);
                chk("out_dec_valid", out_dec_valid_o, exp_q[0].dv);
                chk("out_dec_error", out_dec_error_o, exp_q[0].de);
            end
            chk("cfg_err", cfg_err_o, m_cfg_err);
            chk("s_cfg_err", s_cfg_err, m_cfg_err_s);
            chk("err_cnt", err_cnt_o, m_cnt);
            chk("s_err_cnt", s_err_cnt, m_cnt_s);
            if (out_valid_o && out_ready_i) hs_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cfg_write(input logic [2:0] r, input logic en, input logic [1:0] idx,
                             input logic [31:0] st, input logic [31:0] en_a, input logic commit);
        cfg_we_i = 1'b1; cfg_rule_i = r; cfg_en_i = en; cfg_idx_i = idx;
        cfg_start_i = st; cfg_end_i = en_a; cfg_commit_i = commit;
        tick();
        cfg_we_i = 1'b0; cfg_commit_i = 1'b0;
    endtask

    task automatic send(input logic [31:0] a);
        in_valid_i = 1'b1; in_addr_i = a;
        tick();
        in_valid_i = 1'b0;
    endtask

    logic [31:0] bp_addr [5];
    int          hs_base;

    initial begin
        rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1; en_default_idx_i = 1'b0;
        default_idx_i = 2'd0; cfg_we_i = 1'b0; cfg_en_i = 1'b0; cfg_commit_i = 1'b0;
        cfg_rule_i = 3'd0; cfg_idx_i = 2'd0; cfg_start_i = 32'd0; cfg_end_i = 32'd0;
        in_addr_i = 32'd0;
        bp_addr[0] = 32'h1004; bp_addr[1] = 32'h1104; bp_addr[2] = 32'h1504;
        bp_addr[3] = 32'h9004; bp_addr[4] = 32'h1F00;
        tick(); tick();
        @(negedge clk);
        chk("lit_reset_valid", out_valid_o, 1'b0);
        chk("lit_reset_cnt", err_cnt_o, 16'd0);
        chk("lit_reset_ready", in_ready_o, 1'b1);
        rst_i = 1'b0;
        tick();

        // basic single rule
        cfg_write(3'd0, 1'b1, 2'd1, 32'h1000, 32'h2000, 1'b1);
        send(32'h1800);
        @(negedge clk);
        chk("lit_t1_idx", out_idx_o, 2'd1);
        chk("lit_t1_rule", out_rule_o, 3'd0);
        chk("lit_t1_dv", out_dec_valid_o, 1'b1);

        // overlapping rules: higher slot wins
        cfg_write(3'd2, 1'b1, 2'd3, 32'h1400, 32'h1600, 1'b1);
        send(32'h1500);
        @(negedge clk);
        chk("lit_t2_idx_a", out_idx_o, 2'd3);
        chk("lit_t2_rule_a", out_rule_o, 3'd2);
        send(32'h1700);
        @(negedge clk);
        chk("lit_t2_idx_b", out_idx_o, 2'd1);
        chk("lit_t2_rule_b", out_rule_o, 3'd0);
        send(32'h1600);
        send(32'h0FFF);

        // unmatched: error, default, saturation
        en_default_idx_i = 1'b0;
        send(32'h9000);
        @(negedge clk);
        chk("lit_t3_de", out_dec_error_o, 1'b1);
        chk("lit_t3_cnt1", err_cnt_o, 16'd2);
        en_default_idx_i = 1'b1; default_idx_i = 2'd2;
        send(32'h9000);
        @(negedge clk);
        chk("lit_t3_def_idx", out_idx_o, 2'd2);
        chk("lit_t3_def_de", out_dec_error_o, 1'b0);
        chk("lit_t3_def_cnt", err_cnt_o, 16'd2);
        en_default_idx_i = 1'b0;
        for (int i = 0; i < 8; i++) send(32'h9000);
        @(negedge clk);
        chk("lit_t3_cnt10", err_cnt_o, 16'd10);
        chk("lit_t3_sat", s_err_cnt, 3'd7);
        tick(); tick();

        // backpressure then full-rate drain
        hs_base = hs_cnt;
        out_ready_i = 1'b0; in_valid_i = 1'b1; in_addr_i = bp_addr[0];
        tick();
        in_addr_i = bp_addr[1];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("lit_t4_stall_ready", in_ready_o, 1'b0);
            chk("lit_t4_stall_addr", out_addr_o, 32'h1004);
            tick();
        end
        out_ready_i = 1'b1;
        for (int i = 1; i < 5; i++) begin
            in_addr_i = bp_addr[i];
            tick();
        end
        in_valid_i = 1'b0;
        tick(); tick();
        chk("lit_t4_drained", hs_cnt - hs_base, 5);

        // commit timing
        cfg_write(3'd0, 1'b1, 2'd2, 32'h1000, 32'h2000, 1'b0);
        send(32'h1800);
        @(negedge clk);
        chk("lit_t5_nocommit", out_idx_o, 2'd1);
        cfg_commit_i = 1'b1; in_valid_i = 1'b1; in_addr_i = 32'h1800;
        tick();
        cfg_commit_i = 1'b0; in_addr_i = 32'h1810;
        @(negedge clk);
        chk("lit_t5_old", out_idx_o, 2'd1);
        tick();
        in_valid_i = 1'b0;
        @(negedge clk);
        chk("lit_t5_new", out_idx_o, 2'd2);

        // rejected writes
        cfg_write(3'd0, 1'b1, 2'd3, 32'h3000, 32'h2000, 1'b1);
        @(negedge clk);
        chk("lit_t6_err_pulse", cfg_err_o, 1'b1);
        tick();
        @(negedge clk);
        chk("lit_t6_err_clear", cfg_err_o, 1'b0);
        send(32'h1800);
        @(negedge clk);
        chk("lit_t6_unchanged", out_idx_o, 2'd2);
        cfg_write(3'd7, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        chk("lit_t6_slot_main", cfg_err_o, 1'b0);
        chk("lit_t6_slot_small", s_cfg_err, 1'b1);
        cfg_write(3'd5, 1'b1, 2'd3, 32'hF000_0000, 32'hF000_1000, 1'b1);
        @(negedge clk);
        chk("lit_t6_idx_small", s_cfg_err, 1'b1);
        cfg_write(3'd1, 1'b1, 2'd0, 32'h5000, 32'h5000, 1'b1);
        send(32'h5000);

        // reset with a result in flight
        out_ready_i = 1'b0;
        send(32'h1800);
        @(negedge clk);
        chk("lit_t6_inflight", out_valid_o, 1'b1);
        rst_i = 1'b1;
        tick();
        @(negedge clk);
        chk("lit_t6_rst_valid", out_valid_o, 1'b0);
        rst_i = 1'b0; out_ready_i = 1'b1;
        send(32'h1800);
        @(negedge clk);
        chk("lit_t6_rst_dv", out_dec_valid_o, 1'b0);
        chk("lit_t6_rst_de", out_dec_error_o, 1'b1);
        chk("lit_t6_rst_cnt", err_cnt_o, 16'd1);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
